// File: rtl/fpa_chk_pkg.sv
// Shared state encoding and default geometry for the floating-point adder self-checker.
package fpa_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_NUM_VEC = 8;
    localparam int DEF_LAT     = 3;

endpackage

// File: rtl/fpa_selfcheck_if.sv
// Load port, DUT port and run-status bundle of the self-checker; master drives, slave checks.
interface fpa_selfcheck_if #(
    parameter int WIDTH   = 64,
    parameter int NUM_VEC = 8
);
    localparam int IDX_W = $clog2(NUM_VEC);
    localparam int CNT_W = $clog2(NUM_VEC + 1);

    logic             start;
    logic             ld_we;
    logic [IDX_W-1:0] ld_addr;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;
    logic [WIDTH-1:0] ld_exp;
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic [WIDTH-1:0] dut_res;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [IDX_W-1:0] first_err;

    modport master (
        output start, ld_we, ld_addr, ld_a, ld_b, ld_exp, dut_res,
        input  dut_a, dut_b, busy, done, pass, err_count, first_err
    );

    modport slave (
        input  start, ld_we, ld_addr, ld_a, ld_b, ld_exp, dut_res,
        output dut_a, dut_b, busy, done, pass, err_count, first_err
    );
endinterface

// File: rtl/fpa_chk_vec_ram.sv
// Vector table: one synchronous write port, one asynchronous read port; contents survive reset.
module fpa_chk_vec_ram #(
    parameter int WIDTH   = 64,
    parameter int NUM_VEC = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(NUM_VEC)-1:0] waddr,
    input  logic [3*WIDTH-1:0]         wdata,
    input  logic [$clog2(NUM_VEC)-1:0] raddr,
    output logic [3*WIDTH-1:0]         rdata
);
    localparam int IDX_W = $clog2(NUM_VEC);

    logic [3*WIDTH-1:0] mem_r [NUM_VEC];

    // table write, out-of-range indices dropped for non-power-of-two depths
    always_ff @(posedge clk) begin
        if (we && (waddr <= IDX_W'(NUM_VEC - 1))) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fpa_selfcheck.sv
// Replays a vector table into an adder DUT and scores its delayed results.
// Optional macro CHK_ZERO_SIGN_EQ_EN treats +0 and -0 as equal results.
module fpa_selfcheck
    import fpa_chk_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int LAT     = DEF_LAT
) (
    input  logic                clk,
    input  logic                rst,
    fpa_selfcheck_if.slave      bus
);
    localparam int IDX_W = $clog2(NUM_VEC);
    localparam int CNT_W = $clog2(NUM_VEC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VEC);

    chk_state_t       state_r, state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] dut_a_r, dut_b_r;
    logic             busy_r, done_r, pass_r;
    logic             busy_nxt_s, done_nxt_s, pass_nxt_s;
    logic             issue_s, clear_s, pend_s, tail_hit_s;
    logic [CNT_W-1:0] err_r, err_nxt_s;
    logic [IDX_W-1:0] first_r, first_nxt_s;
    logic [3*WIDTH-1:0] rd_word_s;

    logic             dl_vld_r [LAT];
    logic [IDX_W-1:0] dl_idx_r [LAT];
    logic [WIDTH-1:0] dl_exp_r [LAT];

    function automatic logic res_match(input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] exp);
`ifdef CHK_ZERO_SIGN_EQ_EN
        logic both_zero;
        both_zero = (res[WIDTH-2:0] == {(WIDTH-1){1'b0}}) && (exp[WIDTH-2:0] == {(WIDTH-1){1'b0}});
        return both_zero || (res == exp);
`else
        return res == exp;
`endif
    endfunction

    fpa_chk_vec_ram #(
        .WIDTH   (WIDTH),
        .NUM_VEC (NUM_VEC)
    ) u_vec_ram (
        .clk   (clk),
        .we    (bus.ld_we & ~busy_r),
        .waddr (bus.ld_addr),
        .wdata ({bus.ld_a, bus.ld_b, bus.ld_exp}),
        .raddr (idx_r),
        .rdata (rd_word_s)
    );

    // pending check: a valid entry behind the tail means results are still in flight
    always_comb begin
        pend_s = 1'b0;
        for (int j = 0; j < LAT - 1; j++) begin
            pend_s = pend_s | dl_vld_r[j];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (bus.start) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_IDLE;
            ST_ISSUE: if (idx_r == LAST_IDX) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_ISSUE;
            ST_DRAIN: if (!pend_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_DRAIN;
            ST_DONE:  if (bus.start) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // output decode; status flags are registered from the next state
    always_comb begin
        issue_s    = (state_r == ST_ISSUE);
        clear_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start;
        busy_nxt_s = (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // mismatch accounting on the delay-line tail, including the verdict latched on entry to DONE
    always_comb begin
        tail_hit_s  = dl_vld_r[LAT-1] && !res_match(bus.dut_res, dl_exp_r[LAT-1]);
        err_nxt_s   = err_r;
        first_nxt_s = first_r;
        if (clear_s) begin
            err_nxt_s   = {CNT_W{1'b0}};
            first_nxt_s = {IDX_W{1'b0}};
        end else if (tail_hit_s) begin
            if (err_r != CNT_MAX) err_nxt_s = err_r + CNT_W'(1); else err_nxt_s = err_r;
            if (err_r == {CNT_W{1'b0}}) first_nxt_s = dl_idx_r[LAT-1]; else first_nxt_s = first_r;
        end else begin
            err_nxt_s   = err_r;
            first_nxt_s = first_r;
        end
        if (clear_s) begin
            pass_nxt_s = 1'b0;
        end else if (state_nxt_s == ST_DONE) begin
            pass_nxt_s = (err_nxt_s == {CNT_W{1'b0}});
        end else begin
            pass_nxt_s = pass_r;
        end
    end

    // datapath: vector index, operand registers, delay line and status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r   <= {IDX_W{1'b0}};
            dut_a_r <= {WIDTH{1'b0}};
            dut_b_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= {CNT_W{1'b0}};
            first_r <= {IDX_W{1'b0}};
            for (int j = 0; j < LAT; j++) begin
                dl_vld_r[j] <= 1'b0;
                dl_idx_r[j] <= {IDX_W{1'b0}};
                dl_exp_r[j] <= {WIDTH{1'b0}};
            end
        end else begin
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            pass_r  <= pass_nxt_s;
            err_r   <= err_nxt_s;
            first_r <= first_nxt_s;
            if (clear_s) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (issue_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
            if (issue_s) begin
                dut_a_r <= rd_word_s[3*WIDTH-1:2*WIDTH];
                dut_b_r <= rd_word_s[2*WIDTH-1:WIDTH];
            end
            for (int j = LAT - 1; j > 0; j--) begin
                dl_vld_r[j] <= dl_vld_r[j-1];
                dl_idx_r[j] <= dl_idx_r[j-1];
                dl_exp_r[j] <= dl_exp_r[j-1];
            end
            dl_vld_r[0] <= issue_s;
            dl_idx_r[0] <= idx_r;
            dl_exp_r[0] <= rd_word_s[WIDTH-1:0];
        end
    end

    assign bus.dut_a     = dut_a_r;
    assign bus.dut_b     = dut_b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.first_err = first_r;

endmodule

// File: doc/fpa_selfcheck.md
FPA_SELFCHECK -- requirements
Module: fpa_selfcheck

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand and result width in bits.
REQ-002 SHALL have parameter NUM_VEC, default 8, the vector-table depth; legal range 2..256.
REQ-003 SHALL have parameter LAT, default 3, the DUT latency in clocks; legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a run.
REQ-007 SHALL have port ld_we, input, 1 bit: vector-table write enable.
REQ-008 SHALL have port ld_addr, input, $clog2(NUM_VEC) bits: vector-table write index.
REQ-009 SHALL have ports ld_a, ld_b and ld_exp, input, WIDTH bits each: operand A, operand B and expected sum.
REQ-010 SHALL have ports dut_a and dut_b, output, WIDTH bits each: registered operands to the DUT.
REQ-011 SHALL have port dut_res, input, WIDTH bits: DUT result.
REQ-012 SHALL have ports busy, done and pass, output, 1 bit each: run status.
REQ-013 SHALL have port err_count, output, $clog2(NUM_VEC+1) bits: number of mismatches in the run.
REQ-014 SHALL have port first_err, output, $clog2(NUM_VEC) bits: index of the first mismatch; meaningful only when err_count is non-zero.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-016 IDLE with start=1 SHALL go to ISSUE and clear err_count, first_err and pass.
REQ-017 ISSUE SHALL drive vector i onto dut_a/dut_b, i=0..NUM_VEC-1, one vector per clock; after i=NUM_VEC-1 SHALL go to DRAIN.
REQ-018 On each issue, SHALL push {valid=1, i, exp[i]} into a LAT-deep delay line; in all other cycles it SHALL push valid=0.
REQ-019 The delay-line tail SHALL align so that operands first visible at edge k are compared against dut_res sampled at edge k+LAT.
REQ-020 On a valid tail with dut_res != exp, SHALL increment err_count, and capture first_err only if err_count was 0.
REQ-021 DRAIN SHALL go to DONE on the edge where the delay line holds no valid entry.
REQ-022 A run SHALL take exactly NUM_VEC+LAT cycles from start to done.
REQ-023 DONE SHALL hold done=1 and pass=(err_count==0) until the next start, which restarts at REQ-016.
REQ-024 busy SHALL be 1 exactly in ISSUE and DRAIN.
REQ-025 start while busy SHALL be ignored.
REQ-026 ld_we while busy SHALL be ignored.
REQ-027 ld_we while not busy SHALL write all three fields at ld_addr in one clock.
REQ-028 dut_a/dut_b SHALL hold their last value outside ISSUE.
REQ-029 err_count SHALL never wrap; its maximum value is NUM_VEC.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE.
REQ-031 rst=0 SHALL clear the delay line, dut_a, dut_b, busy, done, pass, err_count and first_err to 0.
REQ-032 Reset mid-run SHALL abort the run with no done pulse.
REQ-033 The vector-table contents SHALL NOT be reset.

Configuration
REQ-034 With CHK_ZERO_SIGN_EQ_EN defined, a result and expected value that are both ±0 (all bits zero except the MSB) SHALL compare equal.
REQ-035 Without CHK_ZERO_SIGN_EQ_EN, comparison SHALL be exact bitwise equality.

Structure
REQ-036 Package fpa_chk_pkg SHALL hold the state encoding and the default WIDTH/NUM_VEC/LAT constants.
REQ-037 The vector table SHALL be sub-module fpa_chk_vec_ram: NUM_VEC x 3*WIDTH, one synchronous write port and one asynchronous read port.

Verification
REQ-038 Load 8 vectors of 4056800000000000+4056800000000000 exp 4066800000000000, LAT=3, start -> done at cycle 11, pass=1, err_count=0.
REQ-039 Same load with exp[5] corrupted to 4066800000000001 -> pass=0, err_count=1, first_err=5.
REQ-040 BFF0000000000000+3FF0000000000000, exp 0000000000000000, DUT returns 8000000000000000 -> mismatch without the macro, pass with CHK_ZERO_SIGN_EQ_EN.
REQ-041 rst low at cycle 4 of a run -> IDLE, all outputs 0; a following start completes normally.
REQ-042 start and ld_we pulsed during DRAIN -> no restart, table unchanged, done at the nominal cycle.
REQ-043 LAT=1, NUM_VEC=2, 4049000000000000+4034000000000000 exp 4051800000000000 -> done at cycle 3, pass=1.
